spgd_dither_sequencer: RTL and testbench
========================================

# spgd_dither_sequencer

Sequencer for the two-channel 14-bit DAC dither stage of the SPGD loop. It drives DAC_A/DAC_B with complementary perturbations around a base value: plus phase (A=base+delta, B=base−delta), then minus phase (swapped). In each phase it waits a programmable settle time, then accumulates a fixed number of ADC metric samples. After each plus/minus pair it reports the signed metric difference J+ − J− to the gradient-update logic.

## Interface
- DAC_WIDTH, 14, DAC code width; codes are unsigned offset-binary.
- ADC_WIDTH, 14, width of signed metric samples.
- CNT_WIDTH, 16, width of the settle and iteration counters.
- AVG_LOG2, 4, log2 of samples accumulated per phase; N = 2^AVG_LOG2.

- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- abort  in  1  immediate stop; takes priority over start.
- base  in  DAC_WIDTH  centre code; latched when start is accepted.
- delta  in  DAC_WIDTH  perturbation amplitude; latched when start is accepted.
- settle_cycles  in  CNT_WIDTH  settle length per phase; latched when start is accepted.
- iterations  in  CNT_WIDTH  number of plus/minus pairs; 0 = continuous. Latched when start is accepted.
- adc_data  in  ADC_WIDTH  signed metric sample.
- adc_valid  in  1  adc_data is valid this cycle.
- DAC_A, DAC_B  out  DAC_WIDTH  registered DAC codes.
- phase  out  1  1 = plus phase active, 0 otherwise.
- busy  out  1  high in any state except IDLE.
- metric_diff  out  ADC_WIDTH+AVG_LOG2+1  signed result J+ − J−; held between updates.
- metric_valid  out  1  one-cycle strobe when metric_diff updates.
- done  out  1  one-cycle strobe when the final programmed pair completes.

## Operation
- States: IDLE, P_SETTLE, P_ACC, M_SETTLE, M_ACC.
- IDLE: DAC_A = DAC_B = latched base. If start=1 and abort=0:
  - latch the configuration inputs;
  - clear the pair counter;
  - go to P_SETTLE.
- P_SETTLE: DAC_A = sat(base+delta), DAC_B = sat(base−delta), phase=1.
  - The state lasts max(settle_cycles,1) cycles.
  - adc_valid is ignored during settle.
- P_ACC: same DAC codes. Each cycle with adc_valid adds adc_data (sign-extended) into sum_p (ADC_WIDTH+AVG_LOG2 bits).
  - The N-th sample moves the FSM to M_SETTLE.
- M_SETTLE / M_ACC: DAC_A = sat(base−delta), DAC_B = sat(base+delta), phase=0.
  - Same settle and accumulate rules as the plus phase, into sum_m.
- On the edge that captures the N-th minus sample:
  - metric_diff <= sum_p − sum_m, computed at full width with no overflow possible;
  - metric_valid <= 1;
  - the pair counter increments.
  - If iterations≠0 and the counter reaches iterations: done <= 1 and go to IDLE.
  - Otherwise clear sum_p and sum_m and go to P_SETTLE.
- Saturation: base+delta clamps to 2^DAC_WIDTH−1; base−delta clamps to 0. Compute both with one extra bit.
- abort=1 in any state: go to IDLE on the next edge.
  - Clear the accumulators and counters.
  - No metric_valid or done is generated.
  - DACs return to the latched base.
- Configuration inputs are ignored while busy.

## Timing
- Reset (asynchronous, rst_n low): state IDLE; DAC_A = DAC_B = 0; latched base = 0; phase, busy, metric_valid and done = 0; metric_diff = 0.
- start sampled at edge E: at E, state becomes P_SETTLE, DAC outputs show plus codes, busy=1 and phase=1. There is no extra output latency.
- Settle occupies exactly max(settle_cycles,1) clock cycles before ACC is entered. The first sample that can be counted is the one presented in the first ACC cycle.
- Phase switch: on the edge that captures the N-th sample, the DAC codes swap.
- metric_valid and done are registered. Both are high for the one cycle immediately after the last minus sample is captured.
- In continuous mode, P_SETTLE re-entry coincides with metric_valid; there is no idle gap.
- adc_valid asserted every cycle gives a pair duration of 2·(max(settle,1)+N) cycles.

## Test plan
- Reset: hold rst_n=0 mid-P_ACC → all outputs 0 asynchronously; after release the block stays in IDLE until start.
- Single pair, AVG_LOG2=2: base=8192, delta=1000, settle=4, iterations=1; adc_data=+100 in plus phase and −50 in minus, adc_valid=1 constant.
  - Required: DAC_A=9192/DAC_B=7192 for 8 cycles, then swapped for 8 cycles.
  - Then metric_diff=600 with metric_valid and done pulsed together for one cycle, after which DACs return to 8192.
- Saturation: base=16000, delta=1000 → plus DAC_A=16383, DAC_B=15000. base=500, delta=1000 → plus DAC_B=0.
- Sparse samples: adc_valid every 3rd cycle, plus pulses on adc_valid during settle.
  - Required: settle samples are ignored; exactly N samples are accumulated per phase; metric_diff is correct.
- Continuous mode: iterations=0 → metric_valid every pair and done never asserted. abort mid-M_ACC → IDLE next cycle with no metric_valid; start+abort in the same cycle is ignored.
- settle_cycles=0 → settle lasts 1 cycle; iterations=3 → exactly 3 metric_valid strobes, and done coincides with the third.

Source files
------------

// File: rtl/spgd_dither_sequencer.sv
// spgd_dither_sequencer: plus/minus DAC dither sequencer with settle, N-sample averaging and J+ - J- reporting
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, abort            run request (IDLE only), immediate stop (wins over start)
//   base, delta             DAC centre code and perturbation, latched on start
//   settle_cycles           settle length per phase (0 behaves as 1), latched on start
//   iterations              plus/minus pairs to run, 0 = continuous, latched on start
//   adc_data, adc_valid     signed metric sample and its qualifier
//   DAC_A, DAC_B            registered DAC codes
//   phase, busy             plus phase active, not IDLE
//   metric_diff             signed J+ - J-, held between updates
//   metric_valid, done      one-cycle strobes at the end of a pair / of the final pair
module spgd_dither_sequencer #(
    parameter int DAC_WIDTH = 14,
    parameter int ADC_WIDTH = 14,
    parameter int CNT_WIDTH = 16,
    parameter int AVG_LOG2  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    input  logic [DAC_WIDTH-1:0]                base,
    input  logic [DAC_WIDTH-1:0]                delta,
    input  logic [CNT_WIDTH-1:0]                settle_cycles,
    input  logic [CNT_WIDTH-1:0]                iterations,
    input  logic signed [ADC_WIDTH-1:0]         adc_data,
    input  logic                                adc_valid,
    output logic [DAC_WIDTH-1:0]                DAC_A,
    output logic [DAC_WIDTH-1:0]                DAC_B,
    output logic                                phase,
    output logic                                busy,
    output logic signed [ADC_WIDTH+AVG_LOG2:0]  metric_diff,
    output logic                                metric_valid,
    output logic                                done
);
    localparam int SW = ADC_WIDTH + AVG_LOG2;

    typedef enum logic [2:0] {IDLE, P_SETTLE, P_ACC, M_SETTLE, M_ACC} state_t;

    state_t                 state;
    logic [DAC_WIDTH-1:0]   base_q, delta_q;
    logic [CNT_WIDTH-1:0]   settle_q, iter_q, cnt, pairs, pairs_nx;
    logic [AVG_LOG2-1:0]    sc;
    logic signed [SW-1:0]   sum_p, sum_m, samp, sum_m_nx;
    logic signed [SW:0]     diff;
    logic [DAC_WIDTH-1:0]   hi_q, lo_q, hi_i, lo_i;

    // Saturating base+delta / base-delta, one extra bit to see carry and borrow
    function automatic logic [2*DAC_WIDTH-1:0] sat(input logic [DAC_WIDTH-1:0] b, input logic [DAC_WIDTH-1:0] d);
        logic [DAC_WIDTH:0] s, t;
        s = {1'b0, b} + {1'b0, d};
        t = {1'b0, b} - {1'b0, d};
        return {s[DAC_WIDTH] ? {DAC_WIDTH{1'b1}} : s[DAC_WIDTH-1:0],
                t[DAC_WIDTH] ? {DAC_WIDTH{1'b0}} : t[DAC_WIDTH-1:0]};
    endfunction

    // Codes for the start edge come from the inputs, since the latches are not loaded yet
    assign {hi_q, lo_q} = sat(base_q, delta_q);
    assign {hi_i, lo_i} = sat(base, delta);
    assign samp         = {{AVG_LOG2{adc_data[ADC_WIDTH-1]}}, adc_data};
    assign sum_m_nx     = sum_m + samp;
    assign diff         = {sum_p[SW-1], sum_p} - {sum_m_nx[SW-1], sum_m_nx};
    assign pairs_nx     = pairs + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            base_q       <= '0;
            delta_q      <= '0;
            settle_q     <= '0;
            iter_q       <= '0;
            cnt          <= '0;
            pairs        <= '0;
            sc           <= '0;
            sum_p        <= '0;
            sum_m        <= '0;
            DAC_A        <= '0;
            DAC_B        <= '0;
            phase        <= 1'b0;
            busy         <= 1'b0;
            metric_diff  <= '0;
            metric_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            metric_valid <= 1'b0;
            done         <= 1'b0;
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
                pairs <= '0;
                sc    <= '0;
                sum_p <= '0;
                sum_m <= '0;
                DAC_A <= base_q;
                DAC_B <= base_q;
                phase <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        DAC_A <= base_q;
                        DAC_B <= base_q;
                        if (start) begin
                            base_q   <= base;
                            delta_q  <= delta;
                            // settle_q holds the last settle count index, so 0 and 1 both give one cycle
                            settle_q <= (settle_cycles == '0) ? '0 : settle_cycles - 1'b1;
                            cnt      <= (settle_cycles == '0) ? '0 : settle_cycles - 1'b1;
                            iter_q   <= iterations;
                            pairs    <= '0;
                            sc       <= '0;
                            sum_p    <= '0;
                            sum_m    <= '0;
                            state    <= P_SETTLE;
                            DAC_A    <= hi_i;
                            DAC_B    <= lo_i;
                            phase    <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    P_SETTLE, M_SETTLE: begin
                        if (cnt == '0)
                            state <= (state == P_SETTLE) ? P_ACC : M_ACC;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    P_ACC: begin
                        if (adc_valid) begin
                            sum_p <= sum_p + samp;
                            sc    <= sc + 1'b1;
                            if (&sc) begin
                                state <= M_SETTLE;
                                cnt   <= settle_q;
                                DAC_A <= lo_q;
                                DAC_B <= hi_q;
                                phase <= 1'b0;
                            end
                        end
                    end
                    M_ACC: begin
                        if (adc_valid) begin
                            sc <= sc + 1'b1;
                            if (&sc) begin
                                metric_diff  <= diff;
                                metric_valid <= 1'b1;
                                pairs        <= pairs_nx;
                                sum_p        <= '0;
                                sum_m        <= '0;
                                if (iter_q != '0 && pairs_nx == iter_q) begin
                                    done  <= 1'b1;
                                    state <= IDLE;
                                    DAC_A <= base_q;
                                    DAC_B <= base_q;
                                    busy  <= 1'b0;
                                end else begin
                                    state <= P_SETTLE;
                                    cnt   <= settle_q;
                                    DAC_A <= hi_q;
                                    DAC_B <= lo_q;
                                    phase <= 1'b1;
                                end
                            end else begin
                                sum_m <= sum_m_nx;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spgd_dither_sequencer.sv
// tb_spgd_dither_sequencer: vector table and timeline stimulus with a metric scoreboard
module tb_spgd_dither_sequencer;
    localparam int NS = 4;
    localparam logic signed [13:0] GARB = 14'sh1fff;

    typedef struct {
        logic [13:0] base;
        logic [13:0] delta;
        logic [15:0] settle;
        logic [15:0] iters;
        int          pv;
        int          mv;
        bit          sparse;
        logic [13:0] hi;
        logic [13:0] lo;
    } vec_t;

    logic               clk = 0;
    logic               rst_n, start, abort, adc_valid;
    logic [13:0]        base, delta;
    logic [15:0]        settle_cycles, iterations;
    logic signed [13:0] adc_data;
    logic [13:0]        dac_a, dac_b;
    logic               phase, busy, mv, done;
    logic signed [16:0] md;

    int     tests = 0;
    int     fails = 0;
    int     cyc   = 0;
    int     nmv   = 0;
    longint sb[$];
    vec_t   vt[6];
    vec_t   vc;

    always #5 clk = ~clk;

    spgd_dither_sequencer #(.DAC_WIDTH(14), .ADC_WIDTH(14), .CNT_WIDTH(16), .AVG_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base(base), .delta(delta),
        .settle_cycles(settle_cycles), .iterations(iterations), .adc_data(adc_data),
        .adc_valid(adc_valid), .DAC_A(dac_a), .DAC_B(dac_b), .phase(phase), .busy(busy),
        .metric_diff(md), .metric_valid(mv), .done(done)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic outs(input string nm, input logic [13:0] ea, input logic [13:0] eb,
                        input logic eph, input logic ebusy, input logic emv, input logic edone);
        chk(nm, {dac_a, dac_b, phase, busy, mv, done}, {ea, eb, eph, ebusy, emv, edone});
    endtask

    // One clock; configuration inputs are scrambled so any use of them while busy shows up
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        base          = 14'($urandom);
        delta         = 14'($urandom);
        settle_cycles = 16'($urandom_range(0, 9));
        iterations    = 16'($urandom_range(0, 5));
    endtask

    always @(negedge clk) begin
        if (rst_n && mv) begin
            nmv++;
            if (sb.size() == 0)
                chk("unexpected_metric_valid", 1, 0);
            else
                chk("metric_diff", longint'(md), sb.pop_front());
        end
    end

    task automatic do_phase(input logic plus, input vec_t v, input logic mv0, input int abort_at);
        int n, s;
        logic [13:0] ea, eb;
        logic vld;
        ea = plus ? v.hi : v.lo;
        eb = plus ? v.lo : v.hi;
        s  = (v.settle == 0) ? 1 : int'(v.settle);
        for (int k = 0; k < s; k++) begin
            outs("settle", ea, eb, plus, 1'b1, (k == 0) && mv0, 1'b0);
            adc_valid = v.sparse && (cyc % 3 == 0);
            adc_data  = GARB;
            step();
        end
        n = 0;
        while (n < NS) begin
            outs("acc", ea, eb, plus, 1'b1, 1'b0, 1'b0);
            vld       = !v.sparse || (cyc % 3 == 0);
            adc_valid = vld;
            adc_data  = vld ? 14'(plus ? v.pv : v.mv) : GARB;
            if (n == abort_at) begin
                abort = 1;
                step();
                abort     = 0;
                adc_valid = 0;
                outs("abort", v.base, v.base, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (vld) n++;
            if (vld && n == NS && !plus) sb.push_back(longint'(NS * (v.pv - v.mv)));
            step();
        end
        adc_valid = 0;
    endtask

    task automatic go(input vec_t v);
        base          = v.base;
        delta         = v.delta;
        settle_cycles = v.settle;
        iterations    = v.iters;
        start         = 1;
        step();
        start = 0;
    endtask

    task automatic run_vec(input vec_t v);
        go(v);
        for (int p = 0; p < int'(v.iters); p++) begin
            do_phase(1'b1, v, p > 0, -1);
            do_phase(1'b0, v, 1'b0, -1);
        end
        outs("pair_done", v.base, v.base, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        outs("back_idle", v.base, v.base, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{14'd8192,  14'd1000,  16'd4, 16'd1, 100,   -50,  1'b0, 14'd9192,  14'd7192};
        vt[1] = '{14'd16000, 14'd1000,  16'd2, 16'd1, 10,    20,   1'b0, 14'd16383, 14'd15000};
        vt[2] = '{14'd500,   14'd1000,  16'd1, 16'd1, -8192, 8191, 1'b0, 14'd1500,  14'd0};
        vt[3] = '{14'd3000,  14'd7,     16'd3, 16'd2, 5,     -5,   1'b1, 14'd3007,  14'd2993};
        vt[4] = '{14'd100,   14'd50,    16'd0, 16'd3, 1,     2,    1'b0, 14'd150,   14'd50};
        vt[5] = '{14'd16383, 14'd16383, 16'd2, 16'd1, 8191,  -8192,1'b0, 14'd16383, 14'd0};
        vc    = '{14'd4000,  14'd300,   16'd2, 16'd0, 7,     3,    1'b0, 14'd4300,  14'd3700};

        rst_n = 0; start = 0; abort = 0; adc_valid = 0; adc_data = 0;
        base = 0; delta = 0; settle_cycles = 0; iterations = 0;
        repeat (2) @(negedge clk);
        outs("reset_state", 14'd0, 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_metric_diff", longint'(md), 0);
        rst_n = 1;
        step();
        outs("idle_after_reset", 14'd0, 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vt[i]) run_vec(vt[i]);

        // Asynchronous reset in the middle of P_ACC
        go(vt[0]);
        adc_valid = 1;
        adc_data  = 100;
        repeat (6) step();
        outs("mid_acc", 14'd9192, 14'd7192, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 0;
        #1;
        outs("async_reset", 14'd0, 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_reset_metric_diff", longint'(md), 0);
        repeat (2) step();
        rst_n     = 1;
        adc_valid = 0;
        repeat (3) step();
        outs("idle_after_release", 14'd0, 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous mode, then abort inside the third minus accumulation
        go(vc);
        do_phase(1'b1, vc, 1'b0, -1);
        do_phase(1'b0, vc, 1'b0, -1);
        do_phase(1'b1, vc, 1'b1, -1);
        do_phase(1'b0, vc, 1'b0, -1);
        do_phase(1'b1, vc, 1'b1, -1);
        do_phase(1'b0, vc, 1'b0, 2);
        step();
        outs("after_abort", 14'd4000, 14'd4000, 1'b0, 1'b0, 1'b0, 1'b0);

        // start together with abort is not accepted
        base = 14'd1234; delta = 14'd10; settle_cycles = 16'd1; iterations = 16'd1;
        start = 1;
        abort = 1;
        step();
        start = 0;
        abort = 0;
        outs("start_abort", 14'd4000, 14'd4000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        outs("start_abort_hold", 14'd4000, 14'd4000, 1'b0, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        chk("metric_strobe_count", nmv, 11);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
